// File: rtl/fifo_rx_pack.sv
// Receive FIFO: packs PACK narrow bytes into one wide word, buffers packed words
// in RAM, and offers them with either a registered or first-word-fall-through read.
module fifo_rx_pack #(
  parameter int IN_WIDTH  = 8,
  parameter int PACK      = 4,
  parameter int DEPTH     = 64,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [IN_WIDTH-1:0]           w_data,
  input  logic                          re,
  input  logic                          flush,
  input  logic                          clr_err,
  output logic [IN_WIDTH*PACK-1:0]      r_data,
  output logic                          r_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(PACK):0]         pack_level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int OUT_W = IN_WIDTH * PACK;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(PACK);

  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C      = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C      = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_P     = (AW+1)'(1);
  localparam logic [PW:0] PACK_LAST = (PW+1)'(PACK - 1);
  localparam logic [PW:0] ONE_L     = (PW+1)'(1);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_vis;
  logic [OUT_W-1:0] pack_buf;
  logic [OUT_W-1:0] word_next;
  logic             accept;
  logic             commit;
  logic             pop;
  logic             load;
  logic             avail;
  logic             ovf_set;
  logic             unf_set;

  // Packer image with the incoming byte dropped into its lane; on the last
  // byte this is the complete word that goes to RAM.
  always_comb begin
    word_next = pack_buf;
    word_next[pack_level*IN_WIDTH +: IN_WIDTH] = w_data;
  end

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C) && (pack_level == PACK_LAST);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // count covers every held word (RAM plus any prefetched output word), so a
  // last byte is only ever accepted when a slot is free at cycle start.
  assign accept = we && !full && !flush;
  assign commit = accept && (pack_level == PACK_LAST);

  // Read side: registered mode pops straight out of RAM into r_data; FWFT
  // prefetches into r_data, sees commits one cycle late (wr_ptr_vis), and
  // refills on the same edge as a pop.
  assign avail = (wr_ptr_vis != rd_ptr);
  assign pop   = (FWFT != 0) ? (re && r_valid && !flush) : (re && !empty && !flush);
  assign load  = (FWFT != 0) ? (avail && (!r_valid || pop) && !flush) : pop;

  assign ovf_set = we && full;
  assign unf_set = (FWFT != 0) ? (re && !r_valid) : (re && empty);

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr[AW-1:0]] <= word_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ptr_vis <= '0;
      count      <= '0;
      pack_level <= '0;
      pack_buf   <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      overflow  <= ovf_set || (overflow && !clr_err);
      underflow <= unf_set || (underflow && !clr_err);
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        wr_ptr_vis <= '0;
        count      <= '0;
        pack_level <= '0;
        pack_buf   <= '0;
        r_valid    <= 1'b0;
      end else begin
        wr_ptr_vis <= wr_ptr;
        if (accept) begin
          pack_buf   <= word_next;
          pack_level <= (pack_level == PACK_LAST) ? '0 : pack_level + ONE_L;
        end
        if (commit) wr_ptr <= wr_ptr + ONE_P;
        if (load) begin
          r_data <= mem[rd_ptr[AW-1:0]];
          rd_ptr <= rd_ptr + ONE_P;
        end
        if (FWFT != 0) r_valid <= load || (r_valid && !pop);
        else           r_valid <= pop;
        if (commit && !pop)      count <= count + ONE_P;
        else if (pop && !commit) count <= count - ONE_P;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rx_pack.sv
// Bench for fifo_rx_pack: one registered-read and one FWFT instance (DEPTH=8,
// PACK=4), driven one at a time and compared against a cycle model.
module tb_fifo_rx_pack;
  localparam int IW = 8;
  localparam int PK = 4;
  localparam int DP = 8;
  localparam int OW = IW * PK;
  localparam int AF = 6;
  localparam int AE = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sel;
  logic          we, re, flush, clr_err;
  logic [IW-1:0] w_data;

  logic          we0, re0, fl0, ce0, we1, re1, fl1, ce1;
  logic [OW-1:0] r_data0, r_data1, r_data;
  logic          r_valid0, r_valid1, r_valid;
  logic          empty0, empty1, empty;
  logic          full0, full1, full;
  logic          af0, af1, af;
  logic          ae0, ae1, ae;
  logic [3:0]    count0, count1, count;
  logic [2:0]    pl0, pl1, pl;
  logic          ovf0, ovf1, ovf;
  logic          unf0, unf1, unf;

  assign we0 = we & ~sel;
  assign re0 = re & ~sel;
  assign fl0 = flush & ~sel;
  assign ce0 = clr_err & ~sel;
  assign we1 = we & sel;
  assign re1 = re & sel;
  assign fl1 = flush & sel;
  assign ce1 = clr_err & sel;

  assign r_data  = sel ? r_data1  : r_data0;
  assign r_valid = sel ? r_valid1 : r_valid0;
  assign empty   = sel ? empty1   : empty0;
  assign full    = sel ? full1    : full0;
  assign af      = sel ? af1      : af0;
  assign ae      = sel ? ae1      : ae0;
  assign count   = sel ? count1   : count0;
  assign pl      = sel ? pl1      : pl0;
  assign ovf     = sel ? ovf1     : ovf0;
  assign unf     = sel ? unf1     : unf0;

  fifo_rx_pack #(.IN_WIDTH(IW), .PACK(PK), .DEPTH(DP), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
    .clk(clk), .rst(rst), .we(we0), .w_data(w_data), .re(re0), .flush(fl0), .clr_err(ce0),
    .r_data(r_data0), .r_valid(r_valid0), .empty(empty0), .full(full0),
    .almost_full(af0), .almost_empty(ae0), .count(count0), .pack_level(pl0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_rx_pack #(.IN_WIDTH(IW), .PACK(PK), .DEPTH(DP), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .we(we1), .w_data(w_data), .re(re1), .flush(fl1), .clr_err(ce1),
    .r_data(r_data1), .r_valid(r_valid1), .empty(empty1), .full(full1),
    .almost_full(af1), .almost_empty(ae1), .count(count1), .pack_level(pl1),
    .overflow(ovf1), .underflow(unf1)
  );

  // scoreboard and reference state
  logic [OW-1:0] exp_q[$];
  int            cyc_q[$];
  int            m_count, m_pack, tcyc, n_commit;
  logic          m_rv, m_ovf, m_unf;
  logic [OW-1:0] m_word;
  int            checks, errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_pack = 0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_word = '0; tcyc = 0;
    exp_q.delete();
    cyc_q.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_pack_level", pl, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_almost_full", af, 1'b0);
    chk("rst_almost_empty", ae, 1'b1);
    chk("rst_overflow", ovf, 1'b0);
    chk("rst_underflow", unf, 1'b0);
  endtask

  task automatic check_outputs();
    logic [OW-1:0] e;
    chk("r_valid", r_valid, m_rv);
    if (m_rv) begin
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        if (sel) chk("r_data", r_data, exp_q[0]);
        else begin
          e = exp_q.pop_front();
          void'(cyc_q.pop_front());
          chk("r_data", r_data, e);
        end
      end
    end
    chk("count", count, m_count);
    chk("pack_level", pl, m_pack);
    chk("empty", empty, m_count == 0);
    chk("full", full, (m_count == DP) && (m_pack == PK - 1));
    chk("almost_full", af, m_count >= AF);
    chk("almost_empty", ae, m_count <= AE);
    chk("overflow", ovf, m_ovf);
    chk("underflow", unf, m_unf);
  endtask

  task automatic model_edge();
    logic fw, full_m, empty_m, pop, acc;
    fw      = sel;
    full_m  = (m_count == DP) && (m_pack == PK - 1);
    empty_m = (m_count == 0);
    m_ovf   = (we && full_m) || (m_ovf && !clr_err);
    m_unf   = (re && (fw ? !m_rv : empty_m)) || (m_unf && !clr_err);
    if (flush) begin
      m_count = 0; m_pack = 0; m_rv = 1'b0; m_word = '0;
      exp_q.delete();
      cyc_q.delete();
    end else begin
      pop = re && (fw ? m_rv : !empty_m);
      acc = we && !full_m;
      if (fw) begin
        if (pop) begin
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
        // a committed word becomes visible to the prefetch two edges later
        if (!(m_rv && !pop)) m_rv = (cyc_q.size() > 0) && (cyc_q[0] <= tcyc - 2);
      end else begin
        m_rv = pop;
      end
      if (acc) begin
        m_word[m_pack*IW +: IW] = w_data;
        if (m_pack == PK - 1) begin
          exp_q.push_back(m_word);
          cyc_q.push_back(tcyc);
          m_pack = 0;
          m_count++;
          n_commit++;
        end else begin
          m_pack++;
        end
      end
      if (pop) m_count--;
    end
    tcyc++;
  endtask

  // driver: called at a falling edge; checks pre-edge outputs, then clocks
  task automatic cyc(input logic w, input logic [IW-1:0] d, input logic r,
                     input logic f, input logic c);
    we = w; w_data = d; re = r; flush = f; clr_err = c;
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wbyte(input logic [IW-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic s);
    sel = s; we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0; w_data = '0;
    rst = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; n_commit = 0;
    sel = 1'b0; rst = 1'b1;
    we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0; w_data = '0;
    model_reset();
    #2;
    @(negedge clk);

    // registered read: pack one word, pop it
    do_reset(1'b0);
    wbyte(8'h11); chk("t1_pl1", pl, 3'd1);
    wbyte(8'h22); chk("t1_pl2", pl, 3'd2);
    wbyte(8'h33); chk("t1_pl3", pl, 3'd3);
    wbyte(8'h44); chk("t1_pl0", pl, 3'd0); chk("t1_count1", count, 4'd1);
    idle(1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_rdata", r_data, 32'h44332211);
    chk("t1_rvalid", r_valid, 1'b1);
    chk("t1_count0", count, 4'd0);
    chk("t1_empty", empty, 1'b1);
    idle(1);
    chk("t1_rvalid_one_cycle", r_valid, 1'b0);
    chk("t1_rdata_hold", r_data, 32'h44332211);

    // fill, full on partial packer, overflow, clr_err
    do_reset(1'b0);
    for (int i = 0; i < 32; i++) wbyte(IW'(i + 1));
    chk("t2_count8", count, 4'd8);
    chk("t2_not_full", full, 1'b0);
    for (int i = 0; i < 3; i++) wbyte(IW'(8'hA0 + i));
    chk("t2_pl3", pl, 3'd3);
    chk("t2_full", full, 1'b1);
    wbyte(8'hEE);
    chk("t2_overflow", ovf, 1'b1);
    chk("t2_count_hold", count, 4'd8);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_cleared", ovf, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // FWFT latency, back-to-back drain, underflow
    do_reset(1'b1);
    wbyte(8'hA0); wbyte(8'hA1); wbyte(8'hA2); wbyte(8'hA3);
    chk("t3_rv_c0", r_valid, 1'b0);
    idle(1);
    chk("t3_rv_c1", r_valid, 1'b0);
    idle(1);
    chk("t3_rv_c2", r_valid, 1'b1);
    chk("t3_rdata", r_data, 32'hA3A2A1A0);
    for (int i = 0; i < 28; i++) wbyte(IW'($urandom_range(0, 255)));
    idle(3);
    chk("t3_count8", count, 4'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_drained", r_valid, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_underflow", unf, 1'b1);

    // random streaming through both read modes
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      n_commit = 0;
      for (int i = 0; i < 4000 && n_commit < 200; i++) begin
        int re_pct;
        re_pct = ((i / 100) % 2 == 0) ? 15 : 55;
        cyc($urandom_range(0, 99) < 70, IW'($urandom_range(0, 255)),
            $urandom_range(0, 99) < re_pct, 1'b0, $urandom_range(0, 99) < 3);
      end
      chk("t4_budget", n_commit >= 200, 1'b1);
      for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_empty_after_drain", empty, 1'b1);
    end

    // simultaneous commit+pop, thresholds
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) wbyte(IW'(8'h30 + i));
    for (int i = 0; i < 3; i++) wbyte(IW'(8'h50 + i));
    chk("t5_count5", count, 4'd5);
    cyc(1'b1, 8'h53, 1'b1, 1'b0, 1'b0);
    chk("t5_count_same", count, 4'd5);
    chk("t5_af0", af, 1'b0);
    for (int i = 0; i < 4; i++) wbyte(IW'(8'h60 + i));
    chk("t5_count6", count, 4'd6);
    chk("t5_af1", af, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t5_ae0", ae, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t5_count1", count, 4'd1);
    chk("t5_ae1", ae, 1'b1);

    // flush against we/re, then async reset mid-stream
    do_reset(1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_unf_set", unf, 1'b1);
    for (int i = 0; i < 14; i++) wbyte(IW'(8'h70 + i));
    idle(3);
    chk("t6_count3", count, 4'd3);
    chk("t6_pl2", pl, 3'd2);
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    chk("t6_flush_count", count, 4'd0);
    chk("t6_flush_pl", pl, 3'd0);
    chk("t6_flush_rvalid", r_valid, 1'b0);
    chk("t6_flush_empty", empty, 1'b1);
    chk("t6_flush_unf_kept", unf, 1'b1);
    for (int i = 0; i < 10; i++) wbyte(IW'(8'h90 + i));
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) wbyte(IW'(8'hC0 + i));
    idle(3);
    chk("t6_post_reset_data", r_data, 32'hC3C2C1C0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
